mem_line_server: RTL and testbench

- Main-memory responder on the far side of the cache miss interface.
- Accepts a line-fill request carrying the missed byte address, reads the 8-word (16-byte) line from an internal word array through a fixed-latency read pipeline, and streams one word per cycle back with memory_data_valid and the word's byte address.
- Also accepts single-word write-through stores.
- Drives memory_busy so the requesting cache's fill FSM can hold off.

---
 rtl/mem_line_server.sv | 183 ++++++++++++++++++
 tb/tb_mem_line_server.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_server.sv
// rtl/mem_line_server.sv - main-memory line-fill responder with write-through stores
//
// Purpose:
//   Sits behind a cache miss interface. A line-fill request reads the 8-word
//   line holding the missed address from an internal word array through a
//   fixed-latency read pipeline and returns one word per cycle. Single-word
//   stores are accepted while no fill is in progress.
//
// Optional feature (macro CRITICAL_WORD_FIRST_EN):
//   defined   - the fill starts at the missed word and wraps through the line
//   undefined - the fill always starts at word 0 of the line
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   fill_req/fill_addr single-cycle line-fill request with missed byte address
//   wr_en/wr_addr/wr_data  single-word store
//   memory_busy        fill in progress (request and stores are illegal)
//   memory_data_valid  memory_data/memory_address carry a returned word
//   memory_data        returned word
//   memory_address     byte address of the returned word
//   fill_done          marks the last word of a fill
//   proto_err          sticky: a request or store arrived while busy

module mem_line_server #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int LATENCY   = 4,
    parameter int MEM_WORDS = 32768
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_req,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              memory_busy,
    output logic              memory_data_valid,
    output logic [DATA_W-1:0] memory_data,
    output logic [ADDR_W-1:0] memory_address,
    output logic              fill_done,
    output logic              proto_err
);

    localparam int BASE_W = ADDR_W - 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t state;
    state_t stateNext;

    logic [BASE_W-1:0] baseLine;
    logic [2:0]        startOff;
    logic [2:0]        issueCnt;
    logic [2:0]        curOff;
    logic              issueNow;
    logic              lastIssue;
    logic              accept;
    logic              wrCommit;
    logic              unusedBits;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    // Stage LATENCY-1 is the output register.
    logic              pipeValid [LATENCY];
    logic              pipeLast  [LATENCY];
    logic [ADDR_W-1:0] pipeAddr  [LATENCY];
    logic [DATA_W-1:0] pipeData  [LATENCY];

    assign memory_busy = (state != IDLE);
    assign accept      = (state == IDLE) && fill_req;
    assign wrCommit    = wr_en && !memory_busy;
    assign issueNow    = (state == ISSUE);
    assign lastIssue   = issueNow && (issueCnt == 3'd7);
    // 3-bit add wraps inside the line, so a fill never leaves its line.
    assign curOff      = startOff + issueCnt;

`ifdef CRITICAL_WORD_FIRST_EN
    assign unusedBits = ^{fill_addr[0], wr_addr[0]};
`else
    assign unusedBits = ^{fill_addr[3:0], wr_addr[0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (fill_req) begin
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                if (issueCnt == 3'd7) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                // Leave once the last word is on the outputs, so the next
                // cycle is the first non-busy one.
                if (pipeValid[LATENCY-1] && pipeLast[LATENCY-1]) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baseLine <= '0;
            startOff <= '0;
            issueCnt <= '0;
        end else if (accept) begin
            baseLine <= fill_addr[ADDR_W-1:4];
`ifdef CRITICAL_WORD_FIRST_EN
            startOff <= fill_addr[3:1];
`else
            startOff <= 3'd0;
`endif
            issueCnt <= 3'd0;
        end else if (issueNow) begin
            issueCnt <= issueCnt + 3'd1;
        end
    end

    // The array is deliberately not reset. A store in the accepting cycle
    // lands before the first read issue, so the fill sees the new value.
    always_ff @(posedge clk) begin
        if (wrCommit) begin
            mem[wr_addr[ADDR_W-1:1]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipeValid[i] <= 1'b0;
                pipeLast[i]  <= 1'b0;
                pipeAddr[i]  <= '0;
                pipeData[i]  <= '0;
            end
        end else begin
            pipeValid[0] <= issueNow;
            pipeLast[0]  <= lastIssue;
            if (issueNow) begin
                pipeAddr[0] <= {baseLine, curOff, 1'b0};
                pipeData[0] <= mem[{baseLine, curOff}];
            end
            for (int i = 1; i < LATENCY; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                pipeLast[i]  <= pipeLast[i-1];
                pipeAddr[i]  <= pipeAddr[i-1];
                pipeData[i]  <= pipeData[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (memory_busy && (wr_en || fill_req)) begin
            proto_err <= 1'b1;
        end
    end

    assign memory_data_valid = pipeValid[LATENCY-1];
    assign memory_data       = pipeData[LATENCY-1];
    assign memory_address    = pipeAddr[LATENCY-1];
    assign fill_done         = pipeLast[LATENCY-1];

endmodule

// File: tb/tb_mem_line_server.sv
// tb/tb_mem_line_server.sv - scoreboard bench for mem_line_server

module tb_mem_line_server;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fill_req;
    logic [15:0] fill_addr;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        memory_busy;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic [15:0] memory_address;
    logic        fill_done;
    logic        proto_err;

    mem_line_server #(
        .ADDR_W(16), .DATA_W(16), .LATENCY(LAT), .MEM_WORDS(32768)
    ) dut (
        .clk(clk), .rst(rst),
        .fill_req(fill_req), .fill_addr(fill_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .memory_busy(memory_busy), .memory_data_valid(memory_data_valid),
        .memory_data(memory_data), .memory_address(memory_address),
        .fill_done(fill_done), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        done;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        monEntry;
    logic [15:0] model [int];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (memory_data_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checkVal("stray_valid", 1, 0);
            end else begin
                monEntry = sbq.pop_front();
                checkVal("ret_cycle", cyc, monEntry.cyc);
                checkVal("ret_addr", memory_address, monEntry.addr);
                checkVal("ret_data", memory_data, monEntry.data);
                checkVal("ret_done", fill_done, monEntry.done);
            end
        end else if (fill_done === 1'b1) begin
            checkVal("done_without_valid", fill_done, 0);
        end
    end

    task automatic pushFill(input logic [15:0] a, input int t);
        logic [2:0] st;
        logic [2:0] off;
        exp_t       e;
`ifdef CRITICAL_WORD_FIRST_EN
        st = a[3:1];
`else
        st = 3'd0;
`endif
        for (int k = 0; k < 8; k++) begin
            off    = st + 3'(k);
            e.addr = {a[15:4], off, 1'b0};
            e.data = model[int'(e.addr[15:1])];
            e.done = (k == 7);
            e.cyc  = t + 1 + k + LAT;
            sbq.push_back(e);
        end
    endtask

    task automatic writeWord(input logic [15:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        model[int'(a[15:1])] = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic doFill(input logic [15:0] a, input bit withWr, input logic [15:0] wa,
                          input logic [15:0] wd, input bit violate);
        int t;
        t = cyc;
        checkVal("busy_before_fill", memory_busy, 0);
        fill_req  = 1'b1;
        fill_addr = a;
        if (withWr) begin
            wr_en   = 1'b1;
            wr_addr = wa;
            wr_data = wd;
            model[int'(wa[15:1])] = wd;
        end
        pushFill(a, t);
        @(posedge clk); #1;
        fill_req = 1'b0;
        wr_en    = 1'b0;
        for (int c = 1; c <= 8 + LAT; c++) begin
            checkVal("busy_during_fill", memory_busy, 1);
            if (violate && c == 3) begin
                wr_en     = 1'b1;
                wr_addr   = {a[15:4], 4'h2};
                wr_data   = 16'hDEAD;
                fill_req  = 1'b1;
                fill_addr = 16'hFFF0;
            end else begin
                wr_en    = 1'b0;
                fill_req = 1'b0;
            end
            @(posedge clk); #1;
        end
        wr_en    = 1'b0;
        fill_req = 1'b0;
        checkVal("busy_after_fill", memory_busy, 0);
        checkVal("sb_drained", sbq.size(), 0);
    endtask

    initial begin
        int t;
        rst       = 1'b1;
        fill_req  = 1'b0;
        fill_addr = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkVal("rst_busy", memory_busy, 0);
        checkVal("rst_valid", memory_data_valid, 0);
        checkVal("rst_data", memory_data, 0);
        checkVal("rst_addr", memory_address, 0);
        checkVal("rst_done", fill_done, 0);
        checkVal("rst_proto_err", proto_err, 0);

        for (int k = 0; k < 8; k++) begin
            writeWord(16'h1410 + 16'(2 * k), 16'h1000 + 16'(k));
        end
        for (int k = 0; k < 8; k++) begin
            writeWord(16'hFFF0 + 16'(2 * k), 16'hA000 + 16'(k));
        end

        doFill(16'h1410, 1'b0, 16'h0, 16'h0, 1'b0);
        doFill(16'h141A, 1'b0, 16'h0, 16'h0, 1'b0);
        doFill(16'h1410, 1'b1, 16'h1414, 16'hBEEF, 1'b0);
        checkVal("proto_err_clean", proto_err, 0);

        doFill(16'h1410, 1'b0, 16'h0, 16'h0, 1'b1);
        checkVal("proto_err_set", proto_err, 1);
        doFill(16'h1410, 1'b0, 16'h0, 16'h0, 1'b0);
        checkVal("proto_err_held", proto_err, 1);

        t = cyc;
        fill_req  = 1'b1;
        fill_addr = 16'h1410;
        pushFill(16'h1410, t);
        @(posedge clk); #1;
        fill_req = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        while (sbq.size() > 0 && sbq[sbq.size()-1].cyc >= t + 8) begin
            void'(sbq.pop_back());
        end
        checkVal("midrst_busy", memory_busy, 0);
        checkVal("midrst_valid", memory_data_valid, 0);
        checkVal("midrst_proto_err", proto_err, 0);
        checkVal("midrst_sb_empty", sbq.size(), 0);
        repeat (10) begin
            @(posedge clk); #1;
            checkVal("valid_after_rst", memory_data_valid, 0);
        end
        doFill(16'h1410, 1'b0, 16'h0, 16'h0, 1'b0);

        doFill(16'hFFF0, 1'b0, 16'h0, 16'h0, 1'b0);
        doFill(16'hFFF6, 1'b0, 16'h0, 16'h0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        checkVal("sb_final_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
